// File: rtl/adder_seq.sv
// Nibble-serial adder/subtractor: one 4-bit ripple-carry slice walks the operands
// LSB nibble first, then publishes sum, carry-out and signed overflow in DONE.
module adder_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 op_cin,
    input  logic                 op_sub,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*NIBBLES-1:0] rsp_sum,
    output logic                 rsp_cout,
    output logic                 rsp_ovf,
    output logic                 busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          fin;
    logic          carry;
    logic          sub_r;
    logic [W-1:0]  a_r, b_r, acc;

    logic [W-1:0]  b_eff, a_sh, b_sh;
    logic [3:0]    ns;
    logic [4:0]    rc;

    // Current nibble is brought down to bit 0 and fed through a 4-bit ripple chain.
    always_comb begin
        b_eff = sub_r ? ~b_r : b_r;
        a_sh  = a_r >> {cnt, 2'b00};
        b_sh  = b_eff >> {cnt, 2'b00};
        rc    = '0;
        ns    = '0;
        rc[0] = carry;
        for (int i = 0; i < 4; i++) begin
            ns[i]   = a_sh[i] ^ b_sh[i] ^ rc[i];
            rc[i+1] = (a_sh[i] & b_sh[i]) | (rc[i] & (a_sh[i] ^ b_sh[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
            fin       <= 1'b0;
            carry     <= 1'b0;
            sub_r     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    a_r       <= op_a;
                    b_r       <= op_b;
                    sub_r     <= op_sub;
                    carry     <= op_sub ? 1'b1 : op_cin;
                    cnt       <= '0;
                    fin       <= 1'b0;
                    state     <= RUN;
                    req_ready <= 1'b0;
                    busy      <= 1'b1;
                end
                RUN: if (!fin) begin
                    for (int i = 0; i < NIBBLES; i++)
                        if (cnt == CW'(i)) acc[i*4 +: 4] <= ns;
                    carry <= rc[4];
                    // Counter parks on the last nibble; fin marks the publish cycle.
                    if (cnt == LAST) fin <= 1'b1;
                    else             cnt <= cnt + 1'b1;
                end else begin
                    rsp_sum   <= acc;
                    rsp_cout  <= carry;
                    rsp_ovf   <= (a_r[W-1] == b_eff[W-1]) && (acc[W-1] != a_r[W-1]);
                    fin       <= 1'b0;
                    state     <= DONE;
                    rsp_valid <= 1'b1;
                end
                DONE: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
